// File: rtl/usb_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_rx : full-speed USB receiver (bit recovery, NRZI, SYNC, unstuff, EOP)
// Rev 1.0
// ---------------------------------------------------------------------------
package types;
  typedef enum logic [1:0] {SE0 = 2'b00, K = 2'b01, J = 2'b10, SE1 = 2'b11} d_port_t;
endpackage

module usb_rx
  import types::*;
#(
  parameter int CLK_MULT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  d_port_t    d_i,
  input  logic       tx_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       active,
  output logic       eop,
  output logic       error
);

  localparam int PHASE_W = (CLK_MULT > 1) ? $clog2(CLK_MULT) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_MULT - 1);
  localparam logic [PHASE_W-1:0] PHASE_MID  = PHASE_W'(CLK_MULT / 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP   = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  d_port_t meta_q, s_q, prev_s_q;
  d_port_t last_sym_q, last_sym_d;
  state_t state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [2:0] zero_cnt_q, zero_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] se0_cnt_q, se0_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d, active_q, active_d, eop_q, eop_d, error_q, error_d;

  logic       en_bit;
  logic       bit_val;
  logic [7:0] shift_next;

  assign en_bit     = (phase_q == PHASE_MID);
  assign bit_val    = (s_q == last_sym_q);
  assign shift_next = {bit_val, shift_q[7:1]};

  always_comb begin
    state_d    = state_q;
    last_sym_d = last_sym_q;
    zero_cnt_d = zero_cnt_q;
    ones_d     = ones_q;
    bit_cnt_d  = bit_cnt_q;
    se0_cnt_d  = se0_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    active_d   = active_q;
    valid_d    = 1'b0;
    eop_d      = 1'b0;
    error_d    = 1'b0;

    // Any line transition re-centres the sampling point within the bit.
    if (s_q != prev_s_q)
      phase_d = PHASE_W'(1);
    else if (phase_q == PHASE_LAST)
      phase_d = '0;
    else
      phase_d = phase_q + PHASE_W'(1);

    if (tx_en) begin
      state_d    = ST_IDLE;
      phase_d    = '0;
      ones_d     = '0;
      bit_cnt_d  = '0;
      last_sym_d = J;
      active_d   = 1'b0;
      data_d     = 8'h00;
    end else if (en_bit) begin
      case (state_q)
        ST_IDLE: begin
          last_sym_d = J;
          if (s_q == K) begin
            state_d    = ST_SYNC;
            zero_cnt_d = 3'd1;
            last_sym_d = K;
          end
        end
        ST_SYNC: begin
          if (s_q == J || s_q == K) begin
            last_sym_d = s_q;
            if (!bit_val) begin
              if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
            end else if (zero_cnt_q >= 3'd3) begin
              state_d   = ST_DATA;
              active_d  = 1'b1;
              bit_cnt_d = '0;
              ones_d    = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          case (s_q)
            J, K: begin
              last_sym_d = s_q;
              if (ones_q == 3'd6) begin
                if (bit_val) begin
                  state_d   = ST_ABORT;
                  error_d   = 1'b1;
                  active_d  = 1'b0;
                  bit_cnt_d = '0;
                end else begin
                  ones_d = '0;
                end
              end else begin
                ones_d    = bit_val ? ones_q + 3'd1 : 3'd0;
                shift_d   = shift_next;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  data_d  = shift_next;
                  valid_d = 1'b1;
                end
              end
            end
            SE0: begin
              // SE0 bypasses the stuff rule; only byte alignment matters here.
              if (bit_cnt_q != 3'd0) begin
                state_d   = ST_ABORT;
                error_d   = 1'b1;
                active_d  = 1'b0;
                bit_cnt_d = '0;
              end else begin
                state_d   = ST_EOP;
                se0_cnt_d = 3'd1;
              end
            end
            default: begin
              state_d   = ST_ABORT;
              error_d   = 1'b1;
              active_d  = 1'b0;
              bit_cnt_d = '0;
            end
          endcase
        end
        ST_EOP: begin
          if (s_q == SE0 && se0_cnt_q != 3'd3) begin
            se0_cnt_d = se0_cnt_q + 3'd1;
          end else if (s_q == J) begin
            state_d    = ST_IDLE;
            eop_d      = 1'b1;
            active_d   = 1'b0;
            last_sym_d = J;
          end else begin
            state_d   = ST_ABORT;
            error_d   = 1'b1;
            active_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end
        ST_ABORT: begin
          // bit_cnt doubles as the consecutive-J counter while aborted.
          if (s_q == J) begin
            if (bit_cnt_q == 3'd7) begin
              state_d    = ST_IDLE;
              bit_cnt_d  = '0;
              last_sym_d = J;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            bit_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q     <= J;
      s_q        <= J;
      prev_s_q   <= J;
      state_q    <= ST_IDLE;
      last_sym_q <= J;
      phase_q    <= '0;
      zero_cnt_q <= '0;
      ones_q     <= '0;
      bit_cnt_q  <= '0;
      se0_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      eop_q      <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      meta_q     <= d_i;
      s_q        <= meta_q;
      prev_s_q   <= s_q;
      state_q    <= state_d;
      last_sym_q <= last_sym_d;
      phase_q    <= phase_d;
      zero_cnt_q <= zero_cnt_d;
      ones_q     <= ones_d;
      bit_cnt_q  <= bit_cnt_d;
      se0_cnt_q  <= se0_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      eop_q      <= eop_d;
      error_q    <= error_d;
    end
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign active = active_q;
  assign eop    = eop_q;
  assign error  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_usb_rx : self-checking bench, packet-level line encoder and event model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_usb_rx;
  import types::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  d_port_t    d_i;
  logic [7:0] data;
  logic       valid, active, eop, error;

  int checks  = 0;
  int errors  = 0;
  int collide = 0;

  // Event words: {kind, payload}; kind 1=byte, 2=eop, 3=error.
  logic [9:0] act_q[$];
  logic [9:0] exp_q[$];
  logic       prev_act = 1'b0;

  d_port_t lvl;
  int      ones;
  bit      jitter = 1'b0;
  bit      jt     = 1'b0;
  logic    bad;

  usb_rx #(.CLK_MULT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .d_i   (d_i),
    .tx_en (tx_en),
    .data  (data),
    .valid (valid),
    .active(active),
    .eop   (eop),
    .error (error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (valid) act_q.push_back({2'd1, data});
    if (eop)   act_q.push_back({2'd2, 6'd0, prev_act, active});
    if (error) act_q.push_back({2'd3, 6'd0, prev_act, active});
    if (int'(valid === 1'b1) + int'(eop === 1'b1) + int'(error === 1'b1) > 1) collide++;
    prev_act = active;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, " count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, " event"}, 32'(act_q[i]), 32'(exp_q[i]));
    act_q.delete();
    exp_q.delete();
  endtask

  function automatic void exp_byte(input logic [7:0] v);
    exp_q.push_back({2'd1, v});
  endfunction
  function automatic void exp_eop();
    exp_q.push_back({2'd2, 8'h02});
  endfunction
  function automatic void exp_err();
    exp_q.push_back({2'd3, 8'h02});
  endfunction

  // Called at posedge+1; holds the symbol for one (possibly jittered) bit time.
  task automatic tx_sym(input d_port_t s);
    int dur;
    if (jitter) begin
      dur = jt ? 5 : 3;
      jt  = !jt;
    end else begin
      dur = 4;
    end
    d_i = s;
    repeat (dur) @(posedge clk);
    #1;
  endtask

  task automatic tx_nrzi(input bit b);
    if (!b) lvl = (lvl == J) ? K : J;
    tx_sym(lvl);
  endtask

  task automatic tx_sync();
    lvl  = J;
    ones = 0;
    for (int i = 0; i < 7; i++) tx_nrzi(1'b0);
    tx_nrzi(1'b1);
  endtask

  task automatic tx_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      tx_nrzi(v[i]);
      ones = v[i] ? ones + 1 : 0;
      if (ones == 6) begin
        tx_nrzi(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic tx_eop();
    tx_sym(SE0);
    tx_sym(SE0);
    tx_sym(J);
  endtask

  task automatic tx_idle(input int n);
    for (int i = 0; i < n; i++) tx_sym(J);
  endtask

  task automatic send_packet(input logic [7:0] bytes[$]);
    tx_sync();
    foreach (bytes[i]) begin
      tx_byte(bytes[i]);
      exp_byte(bytes[i]);
    end
    tx_eop();
    exp_eop();
    tx_idle(10);
  endtask

  initial begin
    logic [7:0] pkt[$];
    logic [7:0] v;
    int nb;

    reset = 1'b1;
    tx_en = 1'b0;
    d_i   = J;
    bad   = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      #1 d_i = d_port_t'($urandom_range(0, 3));
      @(negedge clk);
      if ({valid, active, eop, error} !== 4'b0 || data !== 8'h00) bad = 1'b1;
      @(posedge clk);
    end
    check("reset_outputs_zero", bad, 1'b0);
    #1;
    reset = 1'b0;
    d_i   = J;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("post_reset_valid", valid, 1'b0);
    check("post_reset_active", active, 1'b0);
    check("post_reset_eop", eop, 1'b0);
    check("post_reset_error", error, 1'b0);
    check("post_reset_data", data, 8'h00);
    @(posedge clk);
    #1;
    compare_events("reset");

    // Single byte packet with mid-packet active check.
    tx_idle(4);
    check("idle_active", active, 1'b0);
    tx_sync();
    tx_byte(8'hA5);
    check("data_active", active, 1'b1);
    exp_byte(8'hA5);
    tx_eop();
    exp_eop();
    tx_idle(10);
    check("after_eop_active", active, 1'b0);
    compare_events("pkt_a5");

    // Stuffed run across a byte boundary.
    pkt = '{8'hFF, 8'h01};
    send_packet(pkt);
    compare_events("pkt_ff01");

    // Seven unchanged symbols after SYNC: stuff violation, then recovery.
    tx_sync();
    for (int i = 0; i < 7; i++) tx_nrzi(1'b1);
    exp_err();
    tx_idle(10);
    check("stuff_err_active", active, 1'b0);
    compare_events("stuff_violation");
    pkt = '{8'($urandom)};
    send_packet(pkt);
    compare_events("pkt_after_abort");

    // SE0 after 5 data bits.
    tx_sync();
    for (int i = 0; i < 5; i++) tx_nrzi(1'($urandom_range(0, 1)));
    tx_eop();
    exp_err();
    tx_idle(10);
    compare_events("se0_misaligned");

    // SE0 held 5 bits after a full byte.
    v = 8'($urandom);
    tx_sync();
    tx_byte(v);
    exp_byte(v);
    for (int i = 0; i < 5; i++) tx_sym(SE0);
    exp_err();
    tx_idle(10);
    compare_events("se0_too_long");

    // Bit periods alternating 3/5 clocks.
    jitter = 1'b1;
    jt     = 1'b0;
    tx_sync();
    tx_byte(8'h3C);
    exp_byte(8'h3C);
    tx_eop();
    exp_eop();
    jitter = 1'b0;
    tx_idle(10);
    compare_events("jitter_3c");

    // Local transmitter takes the bus mid-byte.
    tx_sync();
    tx_nrzi(1'b1);
    tx_nrzi(1'b0);
    tx_nrzi(1'b1);
    @(negedge clk);
    check("txen_pre_active", active, 1'b1);
    @(posedge clk);
    #1 tx_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("txen_active_drop", active, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) tx_sym(d_port_t'($urandom_range(0, 3)));
    tx_idle(3);
    check("txen_blank_active", active, 1'b0);
    tx_en = 1'b0;
    tx_idle(10);
    compare_events("tx_en_blank");

    // Random multi-byte packets.
    for (int p = 0; p < 4; p++) begin
      pkt.delete();
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) pkt.push_back(8'($urandom));
      send_packet(pkt);
      compare_events("random_pkt");
    end

    check("strobe_exclusive", collide, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_rx.md
Name: usb_rx

Overview:
- Full-speed USB receiver; the receive-side counterpart of the SIE's transmitter.
- Samples raw D+/D- line state with clk_mult-times oversampling and recovers bit timing from line transitions.
- Performs NRZI decoding, SYNC detection, bit unstuffing, byte assembly and EOP detection.
- Delivers bytes to the SIE as single-cycle strobes, with packet-level active, eop and error flags.

Parameters:
- clk_mult, 4, clk cycles per USB bit time; must be >= 4.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- d_i  input  d_port_t (types::)  USB D+/D- line state (asynchronous); values J, K, SE0, SE1.
- tx_en  input  1  local transmitter driving the bus; blanks the receiver.
- data  output  8  received byte, LSB first on the wire.
- valid  output  1  one-cycle strobe: data holds a new byte.
- active  output  1  high from SYNC end through EOP/abort.
- eop  output  1  one-cycle strobe: valid EOP received.
- error  output  1  one-cycle strobe: stuff, alignment or EOP error.

Behaviour:
- Reset and output values: on reset, and on any cycle with tx_en=1, the FSM goes to IDLE and the phase counter, ones counter and bit counter clear. active, valid, eop and error are 0 and data=8'h00. No strobes are issued while tx_en=1.
- Input synchronizer: 2-flop synchronizer on d_i. All logic uses the synchronized value s; prev_s is s delayed one clk.
- Bit clock recovery: phase counter counts 0..clk_mult-1 and wraps. It loads 1 on the cycle where s != prev_s, otherwise increments. en_bit = (phase == clk_mult/2). The sampled symbol is s at en_bit. This tolerates +/-1 clk of edge jitter at clk_mult=4.
- NRZI decode: decoded bit = 1 if the sampled symbol equals the last sampled J/K symbol, else 0. The last symbol is initialised to J in IDLE.
- FSM states: IDLE, SYNC, DATA, EOP, ABORT.
  - IDLE: first sampled K -> SYNC, with zero count=1. SE0/SE1 are ignored.
  - SYNC: counts decoded 0s. A decoded 1 with zero count >= 3 -> DATA: active<=1, bit and ones counters cleared. A decoded 1 with zero count < 3, or a sampled SE0 -> IDLE silently. SYNC = KJKJKJKK.
  - DATA, bit unstuffing: ones counter increments on a decoded 1 and clears on a decoded 0. When the ones counter is 6, the next bit is a stuff bit. A stuff 0 is dropped and the counter clears. A stuff 1 gives error pulse, active<=0, -> ABORT.
  - DATA, byte assembly: each non-stuff bit shifts into bit 7 of the shift register (shift right). On the 8th bit, data<=shift and valid=1 for exactly one clk, starting the cycle after that en_bit.
  - DATA, exits: sampled SE0 -> EOP, with SE0 count=1. If the bit counter != 0 at that point, error pulse, active<=0 -> ABORT. The stuff rule is not applied to SE0. Sampled SE1 gives error -> ABORT.
  - EOP: sampled SE0 increments the SE0 count. Sampled J with count in 1..3 gives eop pulse, active<=0 -> IDLE. Sampled K, SE1, or a count reaching 4 gives error pulse, active<=0 -> ABORT.
  - ABORT: -> IDLE after 8 consecutive sampled J symbols; any other sample restarts the count.
- Strobe exclusivity: valid, eop and error are mutually exclusive per clk. An error strobe never coincides with valid of a partial byte.
- tx_en rising mid-packet: immediate return to IDLE, active<=0, no error, no eop.

Test Plan (clk_mult=4, 4 clk/bit unless stated):
1. Assert reset with d_i toggling -> data=0, valid=active=eop=error=0 throughout; all remain 0 two bits after release with idle J.
2. Idle J, SYNC, byte 8'hA5, SE0 SE0 J -> active rises after SYNC; one valid with data=8'hA5; one eop; error never asserted; active falls with eop.
3. Bytes 8'hFF, 8'h01 with a stuffed transition after 6 ones -> valid twice with data=8'hFF then 8'h01; no error.
4. Seven unchanged symbols after SYNC (stuff violation) -> one error pulse, active=0, no valid. The next packet after 8 J bits decodes correctly.
5. SE0 after 5 data bits -> error pulse, no eop, no valid. SE0 held 5 bits after a full byte -> valid then error, no eop.
6. Packet 8'h3C with bit periods alternating 3/5 clk -> data=8'h3C, eop, no error. Separately, tx_en=1 mid-byte -> active=0, no strobes.
